cdc_hs_tx: RTL and testbench
============================

# cdc_hs_tx

Source (transmit) end of a four-phase req/ack handshake that carries a DW-bit word out of the `bclk` domain to a receiver in an unrelated clock domain. It accepts words through a valid/ready port and holds one word in a buffer while another is in flight. It drives `req` and `req_data` as registered outputs. The asynchronous `ack` return is resynchronised internally through an SYNC_STAGES-deep flop chain. The block is the counterpart of the team's input synchronizers: those bring asynchronous signals into `bclk`, and this block pushes data safely out of it.

## Interface
- DW, 8: data word width, ≥1.
- SYNC_STAGES, 2: flops in the `ack` synchronizer, ≥2.
- bclk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream word valid.
- in_data  input  DW  upstream word.
- in_ready  output  1  buffer empty; a transfer occurs on an edge where in_valid && in_ready.
- req  output  1  handshake request, registered, glitch-free.
- req_data  output  DW  word presented to the receiver, registered.
- ack  input  1  asynchronous acknowledge from the receiver domain.
- busy  output  1  FSM not in IDLE.
- done  output  1  one-cycle pulse when a handshake fully completes.

## Operation
- Storage: one holding buffer (buf_data, buf_full). Every accepted word enters the buffer; `in_ready` equals !buf_full.
- ack_s: the last stage of the SYNC_STAGES-flop chain on `ack`. All flops in the chain reset to 0.
- FSM states and transitions:
  - IDLE: if buf_full && !ack_s, then req_data←buf_data, req←1, buf_full←0, next state REQ. Otherwise stay in IDLE. A stale high ack, for example after reset, blocks issue.
  - REQ: req is held at 1. When ack_s=1: req←0, next state REL.
  - REL: req is held at 0. When ack_s=0: done←1 for one cycle. Then the next state is selected:
    - If buf_full=1, do the IDLE load action on the same edge and go directly to REQ.
    - Otherwise go to IDLE.
- req_data is only written on an edge where req goes 0→1. It is stable for the whole time req=1 and until the next request.
- An accept and a buffer load may happen on the same edge only if the buffer was full before that edge, and that is impossible because in_ready=0 when the buffer is full. So accept-while-full never occurs and no word is lost.
- busy = (state != IDLE).
- Reset values: state IDLE, req 0, req_data 0, buf_full 0, buf_data 0, done 0, sync chain 0. in_ready is 1 after reset.
- Reset mid-handshake: req drops asynchronously and the in-flight and buffered words are discarded. If the receiver still holds ack high, IDLE waits for ack_s=0 before the next request.

## Timing
- Accept at edge N with an empty buffer, FSM in IDLE and ack_s=0: req=1 after edge N+1. in_ready drops to 0 after edge N and returns to 1 after edge N+1.
- ack rising lands before edge M: ack_s=1 after edge M+SYNC_STAGES-1, and req=0 after edge M+SYNC_STAGES.
- ack falling lands before edge K: done=1 for the cycle after edge K+SYNC_STAGES. With the buffer full, req also rises again at that same edge.
- Minimum transfer period (receiver acknowledges immediately): 2·SYNC_STAGES + 2 bclk cycles plus the receiver's own latency.
- in_valid may stay high continuously. At most two words are outstanding: one in flight and one buffered.

## Test plan
- Reset: hold rst=0 with random inputs. Check req=0, req_data=0, done=0, busy=0 and in_ready=1. After rst=1 with no stimulus, all outputs stay at these values.
- Single word: DW=8, SYNC_STAGES=2, push 0xA5. Check req rises at the 2nd edge after the push and req_data=0xA5. The bench model asserts ack 3 cycles later; check req falls 2 edges after ack is sampled. Drop ack; check done pulses exactly once.
- Back-to-back: push 0x11, 0x22 and 0x33 with in_valid held high. Check in_ready=0 while the buffer holds 0x22, the order on req_data is 0x11, 0x22, 0x33, and 0x22 issues on the same edge as done for 0x11.
- Data stability: random ack delays of 0–20 cycles. Assert req_data never changes while req=1, req never rises while ack_s=1, and the done count equals the accepted-word count.
- Reset mid-handshake: assert rst while in REQ with ack=1. Check req=0 immediately. Release reset with ack still high and push 0x5A; check req stays 0 until ack has been low for 2 edges, then rises with req_data=0x5A.
- Glitchy ack: drive ack with asynchronous edges offset by 0.1–0.9 of the clock period. Check the FSM still follows the IDLE→REQ→REL order with no skipped states.

Source files
------------

// File: rtl/cdc_hs_tx.sv
// rtl/cdc_hs_tx.sv - four-phase req/ack handshake source carrying a DW-bit word out of bclk
// One word may wait in a holding buffer while another is in flight; ack is resynchronised locally.
module cdc_hs_tx #(
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic          bclk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          req,
  output logic [DW-1:0] req_data,
  input  logic          ack,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } state_t;

  state_t                 state, state_d;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic                   buf_full, buf_full_d;
  logic [DW-1:0]          buf_data, buf_data_d;
  logic [DW-1:0]          req_data_d;
  logic                   req_d, done_d;
  logic                   load;

  always_ff @(posedge bclk or negedge rst) begin
    if (!rst) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack};
    end
  end

  assign ack_s    = ack_sync[SYNC_STAGES-1];
  assign in_ready = !buf_full;
  assign busy     = (state != IDLE);

  always_comb begin
    state_d    = state;
    req_d      = req;
    req_data_d = req_data;
    buf_full_d = buf_full;
    buf_data_d = buf_data;
    done_d     = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        // a stale high ack (e.g. after reset) must clear before a new request
        if (buf_full && !ack_s) load = 1'b1;
      end
      REQ: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = REL;
        end
      end
      REL: begin
        if (!ack_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
          if (buf_full) load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      req_data_d = buf_data;
      req_d      = 1'b1;
      buf_full_d = 1'b0;
      state_d    = REQ;
    end
    // accept only ever happens with an empty buffer, so it never collides with a load
    if (in_valid && in_ready) begin
      buf_full_d = 1'b1;
      buf_data_d = in_data;
    end
  end

  always_ff @(posedge bclk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      req      <= 1'b0;
      req_data <= '0;
      buf_full <= 1'b0;
      buf_data <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      req      <= req_d;
      req_data <= req_data_d;
      buf_full <= buf_full_d;
      buf_data <= buf_data_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_cdc_hs_tx.sv
// tb/tb_cdc_hs_tx.sv - self-checking bench for cdc_hs_tx
// Directed steps in one initial block; words are scoreboarded from accept to req rise.
`timescale 1ns/1ps
module tb_cdc_hs_tx;
  localparam int DW = 8;

  logic          bclk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          req;
  logic [DW-1:0] req_data;
  logic          ack;
  logic          busy;
  logic          done;

  logic          man_ack = 1'b0;
  logic          auto_ack = 1'b0;
  logic          auto_ack_v = 1'b0;
  logic          glitchy = 1'b0;
  int            max_dly = 0;

  int            vectors = 0;
  int            miscompares = 0;
  logic [DW-1:0] exp_q[$];
  int            acc_cnt = 0;
  int            done_cnt = 0;
  logic [1:0]    sm;
  logic          prev_acks = 1'b0;
  logic          prev_req = 1'b0;
  logic [DW-1:0] prev_data = '0;
  int            prev_st = 0;

  cdc_hs_tx #(.DW(DW), .SYNC_STAGES(2)) dut (
    .bclk     (bclk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .busy     (busy),
    .done     (done)
  );

  always #5 bclk = ~bclk;
  assign ack = auto_ack ? auto_ack_v : man_ack;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int t = 0; t < 3000 && !(!busy && in_ready && !ack && exp_q.size() == 0); t++)
      @(negedge bclk);
    check(tag, {busy, in_ready, ack}, 3'b010);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  // independent model of the two-flop ack synchronizer
  always @(posedge bclk or negedge rst) begin
    if (!rst) sm <= 2'b00;
    else      sm <= {sm[0], ack};
  end

  always @(posedge bclk) begin
    if (rst && in_valid && in_ready) begin
      exp_q.push_back(in_data);
      acc_cnt++;
    end
  end

  // receiver model: random response delay, optionally off-edge ack transitions
  always begin
    @(negedge bclk);
    if (auto_ack && rst) begin
      if (req && !auto_ack_v) begin
        repeat ($urandom_range(0, max_dly)) @(negedge bclk);
        if (glitchy) #($urandom_range(1, 4) + 5 * $urandom_range(0, 1));
        auto_ack_v = 1'b1;
      end else if (!req && auto_ack_v) begin
        repeat ($urandom_range(0, max_dly)) @(negedge bclk);
        if (glitchy) #($urandom_range(1, 4) + 5 * $urandom_range(0, 1));
        auto_ack_v = 1'b0;
      end
    end
  end

  always @(negedge bclk) begin
    int cur;
    logic [DW-1:0] w;
    if (!rst) begin
      prev_st  = 0;
      prev_req = 1'b0;
    end else begin
      cur = !busy ? 0 : (req ? 1 : 2);
      if (req && !prev_req) begin
        check("no_rise_while_ack_s", prev_acks, 0);
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          check("sb_req_data", req_data, w);
        end
      end
      if (req && prev_req) check("req_data_stable", req_data, prev_data);
      if (done) begin
        done_cnt++;
        check("done_from_rel", prev_st, 2);
      end
      if (cur != prev_st)
        check("fsm_order", (prev_st == 0 && cur == 1) || (prev_st == 1 && cur == 2) ||
                           (prev_st == 2 && cur != 2 && done), 1);
      prev_st  = cur;
      prev_req = req;
    end
    prev_acks = sm[1];
    prev_data = req_data;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int d0;

    // reset with random inputs
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'($urandom);
      in_data  = 8'($urandom);
      man_ack  = 1'($urandom);
      @(negedge bclk);
      check("rst_outputs", {req, done, busy, in_ready}, 4'b0001);
      check("rst_req_data", req_data, 0);
    end
    in_valid = 1'b0;
    man_ack  = 1'b0;
    @(negedge bclk);
    rst = 1'b1;
    repeat (4) begin
      @(negedge bclk);
      check("post_rst_outputs", {req, done, busy, in_ready}, 4'b0001);
      check("post_rst_req_data", req_data, 0);
    end

    // single word 0xA5 with manual ack
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(negedge bclk);
    in_valid = 1'b0;
    check("sw_in_ready_low", in_ready, 0);
    check("sw_req_not_yet", req, 0);
    @(negedge bclk);
    check("sw_req_rise", req, 1);
    check("sw_req_data", req_data, 8'hA5);
    check("sw_in_ready_back", in_ready, 1);
    repeat (3) @(negedge bclk);
    man_ack = 1'b1;
    @(negedge bclk);
    check("sw_req_hold1", req, 1);
    @(negedge bclk);
    check("sw_req_hold2", req, 1);
    @(negedge bclk);
    check("sw_req_fall", {req, busy}, 2'b01);
    man_ack = 1'b0;
    d0 = done_cnt;
    @(negedge bclk);
    check("sw_done_early1", done, 0);
    @(negedge bclk);
    check("sw_done_early2", done, 0);
    @(negedge bclk);
    check("sw_done_pulse", {done, busy}, 2'b10);
    @(negedge bclk);
    check("sw_done_end", done, 0);
    repeat (3) @(negedge bclk);
    check("sw_done_once", done_cnt - d0, 1);

    // back-to-back 0x11, 0x22, 0x33 with in_valid held high
    auto_ack = 1'b1;
    max_dly  = 3;
    in_valid = 1'b1;
    in_data  = 8'h11;
    a0 = acc_cnt;
    for (int t = 0; t < 50 && acc_cnt == a0; t++) @(negedge bclk);
    check("b2b_acc11", acc_cnt - a0, 1);
    in_data = 8'h22;
    a0 = acc_cnt;
    for (int t = 0; t < 50 && acc_cnt == a0; t++) @(negedge bclk);
    check("b2b_acc22", acc_cnt - a0, 1);
    check("b2b_in_ready_full", {in_ready, busy}, 2'b01);
    in_data = 8'h33;
    a0 = acc_cnt;
    for (int t = 0; t < 200 && !done; t++) @(negedge bclk);
    check("b2b_done11", done, 1);
    check("b2b_22_same_edge", req, 1);
    check("b2b_22_data", req_data, 8'h22);
    for (int t = 0; t < 50 && acc_cnt == a0; t++) @(negedge bclk);
    check("b2b_acc33", acc_cnt - a0, 1);
    in_valid = 1'b0;
    wait_idle("b2b_idle");

    // data stability under random ack delays 0..20
    max_dly = 20;
    d0 = done_cnt;
    a0 = acc_cnt;
    for (int i = 0; i < 20; i++) begin
      int a1;
      a1 = acc_cnt;
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      for (int t = 0; t < 500 && acc_cnt == a1; t++) @(negedge bclk);
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge bclk);
    end
    wait_idle("stab_idle");
    check("stab_acc_count", acc_cnt - a0, 20);
    check("stab_done_count", done_cnt - d0, acc_cnt - a0);

    // reset mid-handshake with ack held high
    auto_ack = 1'b0;
    man_ack  = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h77;
    @(negedge bclk);
    in_valid = 1'b0;
    for (int t = 0; t < 20 && !req; t++) @(negedge bclk);
    check("mid_req_up", req, 1);
    man_ack = 1'b1;
    @(negedge bclk);
    check("mid_in_req", {req, busy}, 2'b11);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_req_drop", {req, busy, in_ready}, 3'b001);
    exp_q.delete();
    @(negedge bclk);
    @(negedge bclk);
    rst = 1'b1;
    repeat (3) @(negedge bclk);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    @(negedge bclk);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge bclk);
      check("stale_ack_blocks", req, 0);
    end
    man_ack = 1'b0;
    @(negedge bclk);
    check("ack_low_1", req, 0);
    @(negedge bclk);
    check("ack_low_2", req, 0);
    @(negedge bclk);
    check("ack_low_issue", req, 1);
    check("ack_low_data", req_data, 8'h5A);
    man_ack = 1'b1;
    for (int t = 0; t < 20 && req; t++) @(negedge bclk);
    check("mid_final_fall", req, 0);
    man_ack = 1'b0;
    wait_idle("mid_idle");

    // off-edge ack transitions, continuous in_valid
    auto_ack = 1'b1;
    glitchy  = 1'b1;
    max_dly  = 3;
    d0 = done_cnt;
    a0 = acc_cnt;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      int a1;
      a1 = acc_cnt;
      in_data = 8'($urandom);
      for (int t = 0; t < 200 && acc_cnt == a1; t++) @(negedge bclk);
    end
    in_valid = 1'b0;
    wait_idle("glitch_idle");
    check("glitch_acc_count", acc_cnt - a0, 10);
    check("glitch_done_count", done_cnt - d0, 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
